// File: rtl/leb128_stream_decoder.sv
// Byte-serial LEB128 decoder: gathers 7-bit groups from a valid/ready byte
// stream into an N-bit value (ULEB128 or SLEB128), flags overlong and
// overflowing encodings, and presents the result on a held output handshake.
module leb128_stream_decoder #(
    parameter int N      = 64,
    parameter bit SIGNED = 1'b0,
    parameter int MAXLEN = (N + 6) / 7,
    parameter int LW     = $clog2(MAXLEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  out_data,
    output logic [LW-1:0] out_len,
    output logic          out_err,
    output logic          out_valid,
    input  logic          out_ready
);

    // Scratch width covers every payload position up to the last legal byte,
    // plus margin so shifted masks never need a zero-width slice.
    localparam int WX = 7 * MAXLEN + 8;

    typedef enum logic [1:0] {ACCUM, SKIP, HOLD} state_t;

    state_t          state, state_nx;
    logic [N-1:0]    acc;
    logic [LW-1:0]   cnt;
    logic            err;

    logic            in_fire;
    logic            last_idx;
    logic [WX-1:0]   sh, pmask, hmask, sref, fill;
    logic [N-1:0]    acc_nx, ext, result;
    logic            ovf;

    // Byte count reported for a value, clamped to the longest legal encoding.
    function automatic logic [LW-1:0] sat_len(input int n);
        if (n >= MAXLEN) return LW'(MAXLEN);
        return LW'(n);
    endfunction

    // Place the incoming payload, check the final byte for overflow and
    // build the sign-extended result.
    always_comb begin
        in_fire  = in_valid & in_ready;
        last_idx = (cnt == LW'(MAXLEN - 1));
        sh       = WX'(in_data[6:0]) << (7 * int'(cnt));
        pmask    = WX'(7'h7F) << (7 * int'(cnt));
        hmask    = {WX{1'b1}} << N;
        acc_nx   = acc | sh[N-1:0];
        // Bits beyond N must repeat the value's top bit (signed) or be zero.
        sref     = (SIGNED && acc_nx[N-1]) ? {WX{1'b1}} : '0;
        ovf      = last_idx & (|((sh ^ sref) & pmask & hmask));
        fill     = {WX{1'b1}} << (7 * (int'(cnt) + 1));
        ext      = (SIGNED && in_data[6]) ? fill[N-1:0] : '0;
        result   = acc_nx | ext;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nx;
    end

    // Next-state: a clear bit 7 ends a value; running out of room diverts to SKIP.
    always_comb begin
        state_nx = state;
        case (state)
            ACCUM: if (in_fire) begin
                if (!in_data[7])   state_nx = HOLD;
                else if (last_idx) state_nx = SKIP;
            end
            SKIP:  if (in_fire && !in_data[7]) state_nx = HOLD;
            HOLD:  if (out_ready) state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    // Handshake outputs depend on registered state only.
    always_comb begin
        in_ready  = (state != HOLD);
        out_valid = (state == HOLD);
    end

    // Accumulator, byte counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            out_data <= '0;
            out_len  <= '0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                ACCUM: if (in_fire) begin
                    acc <= acc_nx;
                    cnt <= cnt + LW'(1);
                    if (!in_data[7]) begin
                        out_data <= result;
                        out_len  <= sat_len(int'(cnt) + 1);
                        out_err  <= ovf;
                    end else if (last_idx) begin
                        err <= 1'b1;
                    end
                end
                SKIP: if (in_fire && !in_data[7]) begin
                    out_data <= '0;
                    out_len  <= sat_len(MAXLEN);
                    out_err  <= err;
                end
                HOLD: if (out_ready) begin
                    acc <= '0;
                    cnt <= '0;
                    err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_stream_decoder.sv
// Directed bench: one unsigned and one signed decoder share the byte stream;
// expected values are hand-computed constants.
module tb_leb128_stream_decoder;

    localparam int N  = 64;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          out_ready;

    logic          u_in_ready, u_out_err, u_out_valid;
    logic [N-1:0]  u_out_data;
    logic [LW-1:0] u_out_len;
    logic          s_in_ready, s_out_err, s_out_valid;
    logic [N-1:0]  s_out_data;
    logic [LW-1:0] s_out_len;

    int n_vec  = 0;
    int n_miss = 0;
    logic [7:0] seq[$];

    leb128_stream_decoder #(.N(N), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(u_in_ready), .out_data(u_out_data), .out_len(u_out_len),
        .out_err(u_out_err), .out_valid(u_out_valid), .out_ready(out_ready)
    );

    leb128_stream_decoder #(.N(N), .SIGNED(1'b1)) s_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(s_in_ready), .out_data(s_out_data), .out_len(s_out_len),
        .out_err(s_out_err), .out_valid(s_out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive seq with in_valid held; returns at the negedge after the last byte transfers.
    task automatic send_seq();
        foreach (seq[i]) begin
            int waitc = 0;
            in_data  = seq[i];
            in_valid = 1'b1;
            while (!u_in_ready && waitc < 50) begin
                @(negedge clk);
                waitc++;
            end
            if (waitc >= 50) chk("in_ready_timeout", 64'(u_in_ready), 64'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag,
                              input logic [63:0] ud, input logic [63:0] sd,
                              input logic [3:0] len,
                              input logic ue, input logic se);
        chk({tag, "_uvalid"}, 64'(u_out_valid), 64'd1);
        chk({tag, "_svalid"}, 64'(s_out_valid), 64'd1);
        chk({tag, "_udata"},  u_out_data, ud);
        chk({tag, "_sdata"},  s_out_data, sd);
        chk({tag, "_ulen"},   64'(u_out_len), 64'(len));
        chk({tag, "_slen"},   64'(s_out_len), 64'(len));
        chk({tag, "_uerr"},   64'(u_out_err), 64'(ue));
        chk({tag, "_serr"},   64'(s_out_err), 64'(se));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_valid", 64'(u_out_valid), 64'd0);
        chk("rst_data",  u_out_data, 64'd0);
        chk("rst_len",   64'(u_out_len), 64'd0);
        chk("rst_err",   64'(u_out_err), 64'd0);
        chk("rst_ready", 64'(u_in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic unsigned value, visible one cycle after the final byte
        seq = '{8'hE5, 8'h8E, 8'h26};
        send_seq();
        expect_out("t1", 64'h98765, 64'h98765, 4'd3, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_drop", 64'(u_out_valid), 64'd0);

        // Signed values
        seq = '{8'h7F};
        send_seq();
        expect_out("t2a", 64'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 1'b0, 1'b0);
        seq = '{8'hC0, 8'hBB, 8'h78};
        send_seq();
        expect_out("t2b", 64'h1E_1DC0, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 1'b0, 1'b0);
        seq = '{8'h3F};
        send_seq();
        expect_out("t2c", 64'h3F, 64'h3F, 4'd1, 1'b0, 1'b0);

        // Overlong: 11 continuation bytes then a terminator
        seq.delete();
        repeat (11) seq.push_back(8'h80);
        send_seq();
        chk("t3_skip_ready", 64'(u_in_ready), 64'd1);
        chk("t3_skip_novalid", 64'(u_out_valid), 64'd0);
        seq = '{8'h00};
        send_seq();
        expect_out("t3", 64'd0, 64'd0, 4'd10, 1'b1, 1'b1);
        seq = '{8'h05};
        send_seq();
        expect_out("t3n", 64'd5, 64'd5, 4'd1, 1'b0, 1'b0);

        // Overflow on the tenth byte
        seq.delete();
        repeat (9) seq.push_back(8'hFF);
        seq.push_back(8'h02);
        send_seq();
        expect_out("t4a", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'd10, 1'b1, 1'b1);
        seq.delete();
        repeat (9) seq.push_back(8'hFF);
        seq.push_back(8'h01);
        send_seq();
        expect_out("t4b", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0, 1'b1);

        // Backpressure holds the output and blocks the next byte
        @(negedge clk);
        out_ready = 1'b0;
        seq = '{8'h2A};
        send_seq();
        expect_out("t5", 64'h2A, 64'h2A, 4'd1, 1'b0, 1'b0);
        in_data  = 8'h01;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_hold_valid", 64'(u_out_valid), 64'd1);
            chk("t5_hold_data",  u_out_data, 64'h2A);
            chk("t5_hold_ready", 64'(u_in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_rel_valid", 64'(u_out_valid), 64'd0);
        chk("t5_rel_ready", 64'(u_in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        expect_out("t5n", 64'h01, 64'h01, 4'd1, 1'b0, 1'b0);
        @(negedge clk);

        // Asynchronous reset mid-value
        seq = '{8'hE5, 8'h8E};
        send_seq();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 64'(u_out_valid), 64'd0);
        chk("t6_data",  u_out_data, 64'd0);
        chk("t6_len",   64'(u_out_len), 64'd0);
        chk("t6_err",   64'(u_out_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_noout", 64'(u_out_valid), 64'd0);
        seq = '{8'h26};
        send_seq();
        expect_out("t6", 64'h26, 64'h26, 4'd1, 1'b0, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/leb128_stream_decoder.md
Name: leb128_stream_decoder

Overview:
- Byte-serial LEB128 decoder for the LEB128 datapath.
- Accepts one encoded byte per cycle on a valid/ready stream and accumulates 7-bit groups into an N-bit value.
- Emits the decoded value, its byte length and an error flag on a registered valid/ready output.
- Parametrised successor to the parallel 80-bit unsigned unpacker: any width N, signed (SLEB128) or unsigned (ULEB128) mode, overlong/overflow detection, backpressure.

Parameters:
- N, 64: decoded value width in bits, 8..128.
- SIGNED, 0: 0 = ULEB128 zero-extend; 1 = SLEB128 sign-extend from bit 6 of the final byte.
- MAXLEN, ceil(N/7): maximum legal encoded length in bytes (10 for N=64).
- LW, $clog2(MAXLEN+1): width of out_len.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_data  in  8  encoded byte; bit 7 = continuation, bits 6:0 = payload.
- in_valid  in  1  in_data valid.
- in_ready  out  1  decoder can accept a byte.
- out_data  out  N  decoded value.
- out_len  out  LW  bytes consumed for this value; saturates at MAXLEN.
- out_err  out  1  overlong or overflow encoding.
- out_valid  out  1  out_data/out_len/out_err valid.
- out_ready  in  1  consumer accepts output.

Behaviour:
- Reset (rst_n low, async): state=ACCUM, acc=0, cnt=0, err=0, out_valid=0, out_data=0, out_len=0, out_err=0.
- Input transfer happens when in_valid & in_ready.
- Output transfer happens when out_valid & out_ready.
- in_ready = (state != HOLD). It is registered-state only, with no combinational path from out_ready.
- States:
  - ACCUM: each transferred byte at index cnt ORs payload into acc[7*cnt +: 7]. Bits at or above N are dropped. cnt increments.
    - bit7=0: compute result and go to HOLD.
    - bit7=1 and cnt+1 == MAXLEN: set err, go to SKIP.
  - SKIP: discards bytes until one with bit7=0 is transferred, then goes to HOLD with out_err=1, out_data=0, out_len=MAXLEN.
  - HOLD: out_valid=1 and outputs are stable. On output transfer: clear acc/cnt/err, out_valid=0, go to ACCUM.
- Latency: a terminating byte transferred at edge k gives out_valid=1 after edge k (visible cycle k+1). The next input byte is accepted the cycle after the output transfer. Minimum throughput is one value per (len+1) cycles.
- Overflow check (final index MAXLEN-1 only): payload bits at positions at or above N must be
  - zero when SIGNED=0;
  - equal to bit N-1 when SIGNED=1.
  - Violation: out_err=1, out_data = truncated acc, out_len = actual length.
- Sign extension (SIGNED=1, terminating byte bit6=1, 7*len < N): out_data bits [N-1:7*len] = 1. Otherwise upper bits are 0.
- out_len = number of bytes transferred for this value, 1..MAXLEN. SKIP saturates it at MAXLEN.
- in_valid while in HOLD is ignored (in_ready=0). The upstream source must hold the byte.
- out_ready while out_valid=0 has no effect.
- Reset mid-value (ACCUM/SKIP/HOLD): partial value is discarded, all outputs return to reset values immediately, and no output is emitted for the aborted value.
- No X propagation: in_data is sampled only on transfer.

Test Plan:
1. Unsigned, N=64: bytes E5 8E 26 with in_valid continuous and out_ready=1 -> one output, out_data=624485 (0x98765), out_len=3, out_err=0, out_valid exactly one cycle after the third byte.
2. SIGNED=1, N=64: byte 7F -> out_data=-1 (all ones), len=1. Bytes C0 BB 78 -> out_data=-123456, len=3. Byte 3F -> 63.
3. Overlong: 11×0x80 then 0x00 -> single output, out_err=1, out_data=0, out_len=10. in_ready stays 1 through SKIP. The next value 0x05 decodes to 5 cleanly.
4. Overflow, unsigned N=64: 9×0xFF then 0x02 -> out_err=1, len=10. Same with final 0x01 -> out_data=0xFFFF_FFFF_FFFF_FFFF, err=0.
5. Backpressure: out_ready=0 for 5 cycles after output of value 0x2A -> out_valid/out_data held, in_ready=0 with in_valid high and next byte not consumed. Release -> next value 0x01 decoded correctly.
6. Async reset: assert rst_n=0 between bytes 2 and 3 of E5 8E 26 -> outputs zero immediately. After release, byte 26 alone decodes to 0x26, len=1.
